// File: rtl/pc_pkg.sv
// Shared types and constants for the rv32i fetch-stage PC generator.
// The alignment mask depends on whether PC_COMPRESSED_EN is defined.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } pc_state_e;

  localparam int unsigned INC_32 = 4;
  localparam int unsigned INC_16 = 2;

  // Low address bits that must be zero for a legal redirect target.
  function automatic logic [1:0] align_mask(input logic compressed_en);
    return compressed_en ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Priority select of the next fetch PC (trap > redirect > sequential > hold).
// Also flags misaligned redirects; the alignment rule follows PC_COMPRESSED_EN.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] cur_pc,
  input  logic [XLEN-1:0] inc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            advance,
  output logic [XLEN-1:0] next_pc_c,
  output logic            misalign_c
);

`ifdef PC_COMPRESSED_EN
  localparam logic [1:0] AMASK = align_mask(1'b1);
`else
  localparam logic [1:0] AMASK = align_mask(1'b0);
`endif

  logic target_bad;
  assign target_bad = |(redirect_target[1:0] & AMASK);

  // A misaligned redirect holds the PC; the caller decides what happens next.
  always_comb begin
    next_pc_c  = cur_pc;
    misalign_c = 1'b0;
    if (trap_valid) begin
      next_pc_c = trap_vector;
    end else if (redirect_valid) begin
      if (target_bad) begin
        misalign_c = 1'b1;
      end else begin
        next_pc_c = redirect_target;
      end
    end else if (advance) begin
      next_pc_c = cur_pc + inc;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the rv32i fetch stage: boot hold, fetch handshake,
// trap/redirect steering and misalignment trapping. Optional feature: PC_COMPRESSED_EN.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned    XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned    BOOT_DELAY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            fetch_ready,
`ifdef PC_COMPRESSED_EN
  input  logic            inst_is_c,
`endif
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] link_pc,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr
);

  localparam int unsigned CNT_W = (BOOT_DELAY > 0) ? $clog2(BOOT_DELAY + 1) : 1;

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            misalign_err_q, misalign_err_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

  logic [XLEN-1:0] inc;
  logic [XLEN-1:0] mux_pc_c;
  logic            mux_misalign_c;
  logic            advance;

`ifdef PC_COMPRESSED_EN
  assign inc = inst_is_c ? XLEN'(INC_16) : XLEN'(INC_32);
`else
  assign inc = XLEN'(INC_32);
`endif

  assign advance = fetch_valid_q & fetch_ready & ~stall;

  pc_next_mux #(
    .XLEN(XLEN)
  ) u_next_mux (
    .cur_pc         (pc_q),
    .inc            (inc),
    .trap_valid     (trap_valid),
    .trap_vector    (trap_vector),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .advance        (advance),
    .next_pc_c      (mux_pc_c),
    .misalign_c     (mux_misalign_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= BOOT;
      pc_q            <= RESET_VEC;
      cnt_q           <= CNT_W'(BOOT_DELAY);
      fetch_valid_q   <= 1'b0;
      misalign_err_q  <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      cnt_q           <= cnt_d;
      fetch_valid_q   <= fetch_valid_d;
      misalign_err_q  <= misalign_err_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  // BOOT leaves on the edge where the countdown reaches zero, so fetch_valid
  // stays low for BOOT_DELAY cycles after reset release.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    cnt_d           = cnt_q;
    misalign_addr_d = misalign_addr_q;
    case (state_q)
      BOOT: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (trap_valid) begin
          state_d = RUN;
          pc_d    = trap_vector;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        pc_d = mux_pc_c;
        if (mux_misalign_c) begin
          state_d         = ERR;
          misalign_addr_d = redirect_target;
        end
      end
      ERR: begin
        if (trap_valid) begin
          state_d = RUN;
          pc_d    = trap_vector;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_comb begin
    fetch_valid_d  = (state_d == RUN);
    misalign_err_d = (state_q == RUN) && mux_misalign_c;
  end

  assign fetch_valid   = fetch_valid_q;
  assign fetch_pc      = pc_q;
  assign link_pc       = pc_q + inc;
  assign misalign_err  = misalign_err_q;
  assign misalign_addr = misalign_addr_q;

endmodule
